// File: rtl/uart_fifo_transceiver.sv
// uart_fifo_transceiver: full-duplex UART with TX and RX FIFOs in one clock domain.
// Define UART_PARITY_EN to append and check an even parity bit on both paths.

module uart_sync_fifo #(
  parameter int WIDTH            = 8,
  parameter int DEPTH            = 16,
  parameter bit PUSH_THROUGH_POP = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (level == FULL_LEVEL);
  assign empty   = (level == '0);
  assign pop_ok  = pop && !empty;
  // With PUSH_THROUGH_POP a full FIFO still accepts a push when a pop frees a slot in the same cycle
  assign push_ok = push && (!full || (PUSH_THROUGH_POP && pop_ok));
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop_ok)      level <= level + 1'b1;
      else if (!push_ok && pop_ok) level <= level - 1'b1;
    end
  end
endmodule

module uart_fifo_transceiver #(
  parameter logic [31:0] CLK_FREQ  = 32'd50_000_000,
  parameter logic [31:0] UART_BAUD = 32'd115200,
  parameter int          DATA_BITS = 8,
  parameter int          TX_DEPTH  = 16,
  parameter int          RX_DEPTH  = 16
) (
  input  logic                      uart_clk,
  input  logic                      reset_n,
  input  logic                      tx_fifo_req,
  input  logic [DATA_BITS-1:0]      tx_fifo_data,
  output logic                      tx_fifo_full,
  output logic [$clog2(TX_DEPTH):0] tx_fifo_level,
  output logic                      tx_busy,
  input  logic                      rx_fifo_req,
  output logic [DATA_BITS-1:0]      rx_fifo_data,
  output logic                      rx_fifo_empty,
  output logic [$clog2(RX_DEPTH):0] rx_fifo_level,
  output logic                      rx_overflow,
  output logic                      rx_frame_err,
  output logic                      rx_parity_err,
  input  logic                      uart_rx_path,
  output logic                      uart_tx_path
);
  localparam int BAUD_DIV = int'(CLK_FREQ / UART_BAUD);
  localparam int CW       = $clog2(BAUD_DIV);
  localparam int BW       = $clog2(DATA_BITS);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

  tx_state_t             tx_state;
  logic [CW-1:0]         tx_cnt;
  logic [BW-1:0]         tx_idx;
  logic [DATA_BITS-1:0]  tx_shift;
  logic [DATA_BITS-1:0]  tx_head;
  logic                  tx_empty;
  logic                  tx_pop;

  rx_state_t             rx_state;
  logic [CW-1:0]         rx_cnt;
  logic [BW-1:0]         rx_idx;
  logic [DATA_BITS-1:0]  rx_shift;
  logic [2:0]            rx_sync;
  logic                  rx_bit;
  logic                  rx_fall;
  logic                  rx_full;
  logic                  rx_stop_hit;
  logic                  rx_good;
  logic                  rx_pop_ok;
`ifdef UART_PARITY_EN
  logic                  tx_par;
  logic                  rx_par_bad;
`endif

  uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(TX_DEPTH), .PUSH_THROUGH_POP(1'b0)) u_tx_fifo (
    .clk(uart_clk), .rst_n(reset_n), .push(tx_fifo_req), .push_data(tx_fifo_data),
    .pop(tx_pop), .head(tx_head), .full(tx_fifo_full), .empty(tx_empty), .level(tx_fifo_level)
  );

  uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(RX_DEPTH), .PUSH_THROUGH_POP(1'b1)) u_rx_fifo (
    .clk(uart_clk), .rst_n(reset_n), .push(rx_good), .push_data(rx_shift),
    .pop(rx_fifo_req), .head(rx_fifo_data), .full(rx_full), .empty(rx_fifo_empty),
    .level(rx_fifo_level)
  );

  // A new byte is taken either from idle or at the last stop-bit cycle, so frames run back to back
  assign tx_pop  = !tx_empty &&
                   ((tx_state == TX_IDLE) || ((tx_state == TX_STOP) && (tx_cnt == BIT_LAST)));
  assign tx_busy = (tx_state != TX_IDLE) || !tx_empty;

  always_ff @(posedge uart_clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_state     <= TX_IDLE;
      tx_cnt       <= '0;
      tx_idx       <= '0;
      tx_shift     <= '0;
      uart_tx_path <= 1'b1;
`ifdef UART_PARITY_EN
      tx_par       <= 1'b0;
`endif
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (tx_pop) begin
            tx_shift     <= tx_head;
`ifdef UART_PARITY_EN
            tx_par       <= ^tx_head;
`endif
            tx_cnt       <= '0;
            uart_tx_path <= 1'b0;
            tx_state     <= TX_START;
          end
        end
        TX_START: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt       <= '0;
            tx_idx       <= '0;
            uart_tx_path <= tx_shift[0];
            tx_shift     <= tx_shift >> 1;
            tx_state     <= TX_DATA;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        TX_DATA: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt <= '0;
            if (tx_idx == DATA_LAST) begin
`ifdef UART_PARITY_EN
              uart_tx_path <= tx_par;
              tx_state     <= TX_PARITY;
`else
              uart_tx_path <= 1'b1;
              tx_state     <= TX_STOP;
`endif
            end else begin
              tx_idx       <= tx_idx + 1'b1;
              uart_tx_path <= tx_shift[0];
              tx_shift     <= tx_shift >> 1;
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        TX_PARITY: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt       <= '0;
            uart_tx_path <= 1'b1;
            tx_state     <= TX_STOP;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        TX_STOP: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt <= '0;
            if (tx_pop) begin
              tx_shift     <= tx_head;
`ifdef UART_PARITY_EN
              tx_par       <= ^tx_head;
`endif
              uart_tx_path <= 1'b0;
              tx_state     <= TX_START;
            end else begin
              tx_state <= TX_IDLE;
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  // Two synchroniser stages plus one history stage for falling-edge detection
  always_ff @(posedge uart_clk or negedge reset_n) begin
    if (!reset_n) rx_sync <= 3'b111;
    else          rx_sync <= {rx_sync[1:0], uart_rx_path};
  end

  assign rx_bit      = rx_sync[1];
  assign rx_fall     = rx_sync[2] && !rx_sync[1];
  assign rx_stop_hit = (rx_state == RX_STOP) && (rx_cnt == BIT_LAST);
  assign rx_pop_ok   = rx_fifo_req && !rx_fifo_empty;
`ifdef UART_PARITY_EN
  assign rx_good     = rx_stop_hit && rx_bit && !rx_par_bad;
`else
  assign rx_good     = rx_stop_hit && rx_bit;
  assign rx_parity_err = 1'b0;
`endif

  always_ff @(posedge uart_clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_state      <= RX_IDLE;
      rx_cnt        <= '0;
      rx_idx        <= '0;
      rx_shift      <= '0;
      rx_overflow   <= 1'b0;
      rx_frame_err  <= 1'b0;
`ifdef UART_PARITY_EN
      rx_par_bad    <= 1'b0;
      rx_parity_err <= 1'b0;
`endif
    end else begin
      rx_frame_err  <= rx_stop_hit && !rx_bit;
      rx_overflow   <= rx_good && rx_full && !rx_pop_ok;
`ifdef UART_PARITY_EN
      rx_parity_err <= rx_stop_hit && rx_bit && rx_par_bad;
`endif
      case (rx_state)
        RX_IDLE: begin
          if (rx_fall) begin
            rx_cnt   <= '0;
            rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (rx_cnt == HALF_LAST) begin
            rx_cnt   <= '0;
            rx_idx   <= '0;
            rx_state <= rx_bit ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_bit, rx_shift[DATA_BITS-1:1]};
            if (rx_idx == DATA_LAST) begin
`ifdef UART_PARITY_EN
              rx_state <= RX_PARITY;
`else
              rx_state <= RX_STOP;
`endif
            end else begin
              rx_idx <= rx_idx + 1'b1;
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_PARITY: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt     <= '0;
`ifdef UART_PARITY_EN
            rx_par_bad <= (^rx_shift) ^ rx_bit;
`endif
            rx_state   <= RX_STOP;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= '0;
            rx_state <= RX_IDLE;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_fifo_transceiver.sv
// tb_uart_fifo_transceiver: directed/random bench for uart_fifo_transceiver with a
// serial-line decoder and queue models for both FIFOs.

module tb_uart_fifo_transceiver;
  localparam int DIV   = 16;
  localparam int DBITS = 8;
  localparam int DEPTH = 16;
`ifdef UART_PARITY_EN
  localparam int FBITS = DBITS + 3;
`else
  localparam int FBITS = DBITS + 2;
`endif
  localparam int FRAME = FBITS * DIV;

  logic       uart_clk     = 1'b0;
  logic       reset_n      = 1'b1;
  logic       tx_fifo_req  = 1'b0;
  logic [7:0] tx_fifo_data = 8'h00;
  logic       tx_fifo_full;
  logic [4:0] tx_fifo_level;
  logic       tx_busy;
  logic       rx_fifo_req  = 1'b0;
  logic [7:0] rx_fifo_data;
  logic       rx_fifo_empty;
  logic [4:0] rx_fifo_level;
  logic       rx_overflow;
  logic       rx_frame_err;
  logic       rx_parity_err;
  logic       uart_rx_path;
  logic       uart_tx_path;
  logic       rx_drv   = 1'b1;
  logic       loopback = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int fe_cnt = 0;
  int pe_cnt = 0;
  int ov_cnt = 0;
  bit reset_done = 1'b0;

  logic [7:0] tx_seen[$];
  int         tx_start[$];
  bit         tx_ok[$];
  logic [7:0] tx_model[$];
  logic [7:0] rx_model[$];

  assign uart_rx_path = loopback ? uart_tx_path : rx_drv;

  uart_fifo_transceiver #(
    .CLK_FREQ(32'd1_600_000), .UART_BAUD(32'd100_000), .DATA_BITS(DBITS),
    .TX_DEPTH(DEPTH), .RX_DEPTH(DEPTH)
  ) dut (
    .uart_clk(uart_clk), .reset_n(reset_n),
    .tx_fifo_req(tx_fifo_req), .tx_fifo_data(tx_fifo_data), .tx_fifo_full(tx_fifo_full),
    .tx_fifo_level(tx_fifo_level), .tx_busy(tx_busy),
    .rx_fifo_req(rx_fifo_req), .rx_fifo_data(rx_fifo_data), .rx_fifo_empty(rx_fifo_empty),
    .rx_fifo_level(rx_fifo_level), .rx_overflow(rx_overflow), .rx_frame_err(rx_frame_err),
    .rx_parity_err(rx_parity_err), .uart_rx_path(uart_rx_path), .uart_tx_path(uart_tx_path)
  );

  always #5 uart_clk = ~uart_clk;

  always @(posedge uart_clk) cyc <= cyc + 1;

  // Count every cycle each error output is high, so a stretched pulse shows up as a miscount
  always @(negedge uart_clk) begin
    if (reset_done) begin
      if (rx_frame_err)  fe_cnt <= fe_cnt + 1;
      if (rx_parity_err) pe_cnt <= pe_cnt + 1;
      if (rx_overflow)   ov_cnt <= ov_cnt + 1;
    end
  end

  // Independent UART receiver watching the TX pin, sampling each bit at its centre
  initial begin : tx_monitor
    logic       prev;
    logic [7:0] b;
    logic       good;
    int         st;
    wait (reset_done);
    prev = 1'b1;
    forever begin
      @(negedge uart_clk);
      if (prev && !uart_tx_path) begin
        st = cyc;
        repeat (DIV/2) @(negedge uart_clk);
        good = (uart_tx_path == 1'b0);
        for (int i = 0; i < DBITS; i++) begin
          repeat (DIV) @(negedge uart_clk);
          b[i] = uart_tx_path;
        end
`ifdef UART_PARITY_EN
        repeat (DIV) @(negedge uart_clk);
        if (uart_tx_path !== ^b) good = 1'b0;
`endif
        repeat (DIV) @(negedge uart_clk);
        if (uart_tx_path !== 1'b1) good = 1'b0;
        tx_seen.push_back(b);
        tx_start.push_back(st);
        tx_ok.push_back(good);
        prev = uart_tx_path;
      end else begin
        prev = uart_tx_path;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Drive one serial frame onto the RX pin; stop_bit/flip_par allow corrupt frames
  task automatic applyStimulus(input logic [7:0] data, input logic stop_bit,
                               input logic flip_par);
    rx_drv = 1'b0;
    repeat (DIV) @(negedge uart_clk);
    for (int i = 0; i < DBITS; i++) begin
      rx_drv = data[i];
      repeat (DIV) @(negedge uart_clk);
    end
`ifdef UART_PARITY_EN
    rx_drv = (^data) ^ flip_par;
    repeat (DIV) @(negedge uart_clk);
`else
    if (flip_par) rx_drv = 1'b1;
`endif
    rx_drv = stop_bit;
    repeat (DIV) @(negedge uart_clk);
    rx_drv = 1'b1;
  endtask

  task automatic pushTx(input logic [7:0] data);
    tx_fifo_req  = 1'b1;
    tx_fifo_data = data;
    @(negedge uart_clk);
    tx_fifo_req  = 1'b0;
  endtask

  task automatic popRx(input string tag);
    logic [7:0] exp;
    exp = rx_model.pop_front();
    checkOutput(tag, rx_fifo_data, exp);
    rx_fifo_req = 1'b1;
    @(negedge uart_clk);
    rx_fifo_req = 1'b0;
  endtask

  task automatic waitTxFrames(input int n, input int limit);
    int k;
    k = 0;
    while (tx_seen.size() < n && k < limit) begin
      @(negedge uart_clk);
      k++;
    end
    checkOutput("tx_frame_count", tx_seen.size(), n);
  endtask

  task automatic waitRxLevel(input int n, input int limit);
    int k;
    k = 0;
    while (int'(rx_fifo_level) < n && k < limit) begin
      @(negedge uart_clk);
      k++;
    end
    checkOutput("rx_level_reached", rx_fifo_level, n);
  endtask

  task automatic clearTx();
    tx_seen.delete();
    tx_start.delete();
    tx_ok.delete();
    tx_model.delete();
  endtask

  initial begin : stimulus
    logic [7:0] b;
    int occ;
    bit started;
    bit accept;
    bit pop;
    int fe0;
    int pe0;
    int ov0;

    #2 reset_n = 1'b0;
    repeat (3) @(negedge uart_clk);
    checkOutput("rst_tx_line", uart_tx_path, 1);
    checkOutput("rst_tx_full", tx_fifo_full, 0);
    checkOutput("rst_tx_level", tx_fifo_level, 0);
    checkOutput("rst_tx_busy", tx_busy, 0);
    checkOutput("rst_rx_empty", rx_fifo_empty, 1);
    checkOutput("rst_rx_level", rx_fifo_level, 0);
    checkOutput("rst_rx_data", rx_fifo_data, 0);
    checkOutput("rst_frame_err", rx_frame_err, 0);
    checkOutput("rst_overflow", rx_overflow, 0);
    checkOutput("rst_parity_err", rx_parity_err, 0);
    reset_n = 1'b1;
    reset_done = 1'b1;
    @(negedge uart_clk);

    // Single byte: start bit one cycle after the push, busy for exactly one frame
    clearTx();
    pushTx(8'hA5);
    checkOutput("a5_tx_level", tx_fifo_level, 1);
    checkOutput("a5_busy_on", tx_busy, 1);
    @(negedge uart_clk);
    checkOutput("a5_start_bit", uart_tx_path, 0);
    checkOutput("a5_popped", tx_fifo_level, 0);
    repeat (FRAME - 2) @(negedge uart_clk);
    checkOutput("a5_busy_late", tx_busy, 1);
    repeat (3) @(negedge uart_clk);
    checkOutput("a5_busy_off", tx_busy, 0);
    checkOutput("a5_line_idle", uart_tx_path, 1);
    waitTxFrames(1, 10);
    if (tx_seen.size() > 0) begin
      checkOutput("a5_byte", tx_seen[0], 8'hA5);
      checkOutput("a5_framing", tx_ok[0], 1);
    end

    // Burst of 18 pushes: model occupancy with push-before-full and one pop when idle
    clearTx();
    occ = 0;
    started = 1'b0;
    for (int i = 0; i < 18; i++) begin
      b = 8'($urandom);
      accept = (occ < DEPTH);
      pop = (occ > 0) && !started;
      if (pop) started = 1'b1;
      if (accept) tx_model.push_back(b);
      occ = occ + int'(accept) - int'(pop);
      pushTx(b);
      checkOutput($sformatf("burst_level_%0d", i), tx_fifo_level, occ);
      checkOutput($sformatf("burst_full_%0d", i), tx_fifo_full, (occ == DEPTH));
    end
    waitTxFrames(17, 18 * FRAME);
    for (int i = 0; i < 17 && i < tx_seen.size(); i++) begin
      checkOutput($sformatf("burst_byte_%0d", i), tx_seen[i], tx_model[i]);
      checkOutput($sformatf("burst_frame_%0d", i), tx_ok[i], 1);
      if (i > 0) checkOutput($sformatf("burst_gap_%0d", i), tx_start[i] - tx_start[i-1], FRAME);
    end
    repeat (DIV) @(negedge uart_clk);
    checkOutput("burst_busy_off", tx_busy, 0);
    checkOutput("burst_level_end", tx_fifo_level, 0);

    // Loopback: TX pin feeds RX pin
    loopback = 1'b1;
    rx_model.delete();
    pushTx(8'h3C);
    rx_model.push_back(8'h3C);
    waitRxLevel(1, 3 * FRAME);
    checkOutput("lb_empty", rx_fifo_empty, 0);
    checkOutput("lb_data", rx_fifo_data, 8'h3C);
    for (int i = 0; i < 2; i++) begin
      b = 8'($urandom);
      rx_model.push_back(b);
      pushTx(b);
    end
    waitRxLevel(3, 4 * FRAME);
    repeat (DIV) @(negedge uart_clk);
    loopback = 1'b0;
    for (int i = 0; i < 3; i++) popRx($sformatf("lb_pop_%0d", i));
    checkOutput("lb_empty_end", rx_fifo_empty, 1);
    checkOutput("lb_no_frame_err", fe_cnt, 0);
    checkOutput("lb_no_overflow", ov_cnt, 0);

    // Short low glitch on RX must be rejected silently, then a real frame still lands
    fe0 = fe_cnt; pe0 = pe_cnt; ov0 = ov_cnt;
    rx_drv = 1'b0;
    repeat (DIV/4) @(negedge uart_clk);
    rx_drv = 1'b1;
    repeat (3 * DIV) @(negedge uart_clk);
    checkOutput("glitch_level", rx_fifo_level, 0);
    checkOutput("glitch_frame_err", fe_cnt, fe0);
    checkOutput("glitch_parity_err", pe_cnt, pe0);
    checkOutput("glitch_overflow", ov_cnt, ov0);
    b = 8'($urandom);
    rx_model.push_back(b);
    applyStimulus(b, 1'b1, 1'b0);
    repeat (DIV) @(negedge uart_clk);
    checkOutput("glitch_recover_level", rx_fifo_level, 1);
    popRx("glitch_recover_data");

    // Stop bit low: exactly one frame-error cycle, nothing stored
    fe0 = fe_cnt; pe0 = pe_cnt;
    applyStimulus(8'($urandom), 1'b0, 1'b0);
    repeat (DIV) @(negedge uart_clk);
    checkOutput("ferr_pulse", fe_cnt, fe0 + 1);
    checkOutput("ferr_level", rx_fifo_level, 0);
    checkOutput("ferr_no_parity", pe_cnt, pe0);
    b = 8'($urandom);
    rx_model.push_back(b);
    applyStimulus(b, 1'b1, 1'b0);
    repeat (DIV) @(negedge uart_clk);
    checkOutput("ferr_recover_level", rx_fifo_level, 1);
    popRx("ferr_recover_data");

`ifdef UART_PARITY_EN
    fe0 = fe_cnt; pe0 = pe_cnt;
    applyStimulus(8'($urandom), 1'b1, 1'b1);
    repeat (DIV) @(negedge uart_clk);
    checkOutput("perr_pulse", pe_cnt, pe0 + 1);
    checkOutput("perr_level", rx_fifo_level, 0);
    checkOutput("perr_no_frame", fe_cnt, fe0);
    applyStimulus(8'($urandom), 1'b0, 1'b1);
    repeat (DIV) @(negedge uart_clk);
    checkOutput("both_err_frame", fe_cnt, fe0 + 1);
    checkOutput("both_err_parity", pe_cnt, pe0 + 1);
`endif

    // Fill RX, then one more frame overflows and is dropped
    ov0 = ov_cnt;
    for (int i = 0; i < DEPTH + 1; i++) begin
      b = 8'($urandom);
      if (rx_model.size() < DEPTH) rx_model.push_back(b);
      applyStimulus(b, 1'b1, 1'b0);
    end
    repeat (DIV) @(negedge uart_clk);
    checkOutput("ovf_pulse", ov_cnt, ov0 + 1);
    checkOutput("ovf_level", rx_fifo_level, DEPTH);
    checkOutput("ovf_head", rx_fifo_data, rx_model[0]);
    for (int i = 0; i < DEPTH; i++) popRx($sformatf("ovf_pop_%0d", i));
    checkOutput("ovf_empty_end", rx_fifo_empty, 1);
`ifndef UART_PARITY_EN
    checkOutput("parity_tied_off", pe_cnt, 0);
`endif

    // Reset during a frame forces the line high and empties the TX side at once
    pushTx(8'h00);
    pushTx(8'h00);
    repeat (3 * DIV) @(negedge uart_clk);
    checkOutput("midrst_line_low", uart_tx_path, 0);
    reset_n = 1'b0;
    #1;
    checkOutput("midrst_line_high", uart_tx_path, 1);
    checkOutput("midrst_tx_level", tx_fifo_level, 0);
    checkOutput("midrst_busy", tx_busy, 0);
    @(negedge uart_clk);
    reset_n = 1'b1;
    repeat (2) @(negedge uart_clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
